dram_burst_loader: RTL and testbench
====================================

# dram_burst_loader

Streams a contiguous byte range out of the byte-wide DRAM model (`simple_memory`) and packs it into wide words for the accelerator datapath. The loader drives the memory's address port one byte per cycle and absorbs the memory's one-cycle registered read latency. It presents little-endian packed words on a valid/ready stream with a last flag. It sits directly between `simple_memory` and the buffer-fill logic of the load instruction.

## Interface
- `ADDR_WIDTH`, 24: byte address width; must match the memory.
- `WORD_BYTES`, 4: bytes per output word; allowed range 2..16.
- `LEN_WIDTH`, 20: width of the byte-count request field.

Ports:
- `clk` in 1: the only clock; all state is updated on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: request strobe; sampled only while `busy`=0.
- `base_addr` in ADDR_WIDTH: first byte address, sampled with `start`.
- `length` in LEN_WIDTH: number of bytes to load, sampled with `start`.
- `busy` out 1: a request is in progress.
- `done` out 1: single-cycle pulse at request completion.
- `mem_addr` out ADDR_WIDTH: address to the memory.
- `mem_we` out 1: memory write enable; tied to 0.
- `mem_dout` in 8: memory read data, valid one cycle after the address.
- `out_data` out WORD_BYTES*8: packed word.
- `out_valid` out 1: `out_data` holds a word.
- `out_ready` in 1: consumer accepts the word.
- `out_last` out 1: the current word is the final word of the request.

## Operation
- FSM states:
  - IDLE → (`start` && `length`≠0) → FETCH.
  - IDLE → (`start` && `length`=0) → FINISH.
  - FETCH → (last byte issued) → DRAIN.
  - DRAIN → (final word handshake) → FINISH.
  - FINISH → IDLE after one cycle, with `done`=1 during FINISH.
- `busy` = (state ≠ IDLE && state ≠ FINISH).
- A `start` raised while `busy`=1 is ignored.
- FETCH issues one address per cycle: base, base+1, and so on. Addresses wrap modulo 2^ADDR_WIDTH.
- Each returned byte is placed in pack-register lane (byte index mod WORD_BYTES). Lane 0 is `out_data[7:0]`.
- When a word completes, it moves to the output register. A word completes when its last lane is filled or when the final byte of the request arrives.
  - Unfilled lanes of a short final word are 0.
  - `out_last` is set only on the final word.
- Backpressure rule: the address of a word's last lane is issued only if the output slot will be free when that byte returns. That holds when `out_valid`=0, or when `out_valid`&&`out_ready` in the issue cycle.
  - Otherwise `mem_addr` holds its value. The repeated read is harmless.
  - No byte is dropped or duplicated.
- The word count is ceil(`length`/WORD_BYTES).
- The output register holds its contents until the handshake.

## Timing
- Reset values:
  - State IDLE.
  - `busy`, `done`, `out_valid`, `out_last` = 0.
  - `out_data` = 0.
  - `mem_addr` = 0.
  - `mem_we` = 0.
- `start` in cycle 0 places `mem_addr`=base in cycle 1.
- Each byte is captured at the end of the cycle after its address.
- The first word has `out_valid`=1 in cycle WORD_BYTES+2, assuming no stalls.
- Sustained throughput is 1 byte/cycle while `out_ready`=1.
- `done` pulses in the cycle after the final `out_valid`&&`out_ready`&&`out_last`. The next `start` is accepted in that same `done` cycle.
- A `length`=0 request gives `done` in cycle 1 and no output words.
- Asserting `rst_n` mid-request clears everything immediately. Pending and partial words are discarded.

## Configuration
- `DRAM_LOADER_BIG_ENDIAN_EN` defined: byte index i lands in lane WORD_BYTES-1-(i mod WORD_BYTES). The first byte is in the MSBs.
  - Padding of a short final word is still 0, in the low lanes.
- Not defined: the little-endian packing described above.
- All timing is identical in both builds.

## Test plan
- Basic load: memory[0x100..0x107] = 01..08, base 0x100, length 8, `out_ready`=1.
  - Words 0x04030201, then 0x08070605 with `out_last`.
  - First `out_valid` in cycle 6; `done` in cycle 11.
- Short tail: length 6 from the same data.
  - Second word is 0x00000605 with `out_last`=1.
  - Exactly 2 handshakes.
- Backpressure: length 12 with `out_ready` low for cycles 6..15.
  - Word 0 is held stable; `mem_addr` stalls on the last-lane address.
  - All 3 words are correct, with no duplicates.
- Edge requests:
  - length 0: `done` in cycle 1, no `out_valid`.
  - `start` pulsed while `busy`: no effect on the in-flight transfer.
- Wrap and reset:
  - base 0xFFFFFE, length 4: `mem_addr` sequence FFFFFE, FFFFFF, 000000, 000001.
  - `rst_n` low mid-burst: all outputs are 0 at once, and a new request then works correctly.
- Big-endian build: the basic load yields 0x01020304, then 0x05060708.

Source files
------------

// File: rtl/dram_burst_loader.sv
// Streams a byte range from the byte-wide DRAM model and packs it into WORD_BYTES-wide words on a valid/ready stream.
// Optional DRAM_LOADER_BIG_ENDIAN_EN places the first byte in the MSB lane; the default build packs little-endian.
module dram_burst_loader #(
  parameter int ADDR_WIDTH = 24,
  parameter int WORD_BYTES = 4,
  parameter int LEN_WIDTH  = 20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [LEN_WIDTH-1:0]    length,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_we,
  input  logic [7:0]              mem_dout,
  output logic [WORD_BYTES*8-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last
);
  localparam int LW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int DW = WORD_BYTES * 8;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FINISH} state_t;
  state_t state, state_nxt;

  logic [LEN_WIDTH-1:0] len_reg;
  logic [LEN_WIDTH-1:0] issue_idx;
  logic [LW-1:0]        lane_cnt;
  logic                 accept;
  logic                 issue_final;
  logic                 issue_wend;
  logic                 slot_free;
  logic                 issue;
  logic                 rd_vld;
  logic                 rd_final;
  logic                 rd_wend;
  logic [LW-1:0]        rd_lane;
  logic [DW-1:0]        pack;
  logic [DW-1:0]        merged;

  function automatic logic [LW-1:0] phys_lane(input logic [LW-1:0] l);
`ifdef DRAM_LOADER_BIG_ENDIAN_EN
    return LW'(WORD_BYTES - 1) - l;
`else
    return l;
`endif
  endfunction

  assign mem_we      = 1'b0;
  assign accept      = start && (state == IDLE || state == FINISH);
  assign issue_final = (issue_idx == len_reg - LEN_WIDTH'(1));
  assign issue_wend  = issue_final || (lane_cnt == LW'(WORD_BYTES - 1));
  // A word-completing byte lands one cycle after issue, so the output slot must be free by then.
  assign slot_free   = !out_valid || out_ready;
  assign issue       = (state == FETCH) && (!issue_wend || slot_free);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (length == '0) ? FINISH : FETCH;
      end
      FETCH: begin
        busy = 1'b1;
        if (issue && issue_final) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (out_valid && out_ready && out_last) state_nxt = FINISH;
      end
      FINISH: begin
        done = 1'b1;
        if (start) state_nxt = (length == '0) ? FINISH : FETCH;
        else       state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    merged = pack;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (rd_lane == LW'(i)) merged[i*8 +: 8] = mem_dout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      len_reg   <= '0;
      issue_idx <= '0;
      lane_cnt  <= '0;
      rd_vld    <= 1'b0;
      rd_final  <= 1'b0;
      rd_wend   <= 1'b0;
      rd_lane   <= '0;
      pack      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      // Stalled cycles re-present the same address; their returned byte is ignored.
      rd_vld   <= issue;
      rd_final <= issue_final;
      rd_wend  <= issue_wend;
      rd_lane  <= phys_lane(lane_cnt);

      if (accept) begin
        mem_addr  <= base_addr;
        len_reg   <= length;
        issue_idx <= '0;
        lane_cnt  <= '0;
      end else if (issue) begin
        if (!issue_final) begin
          mem_addr  <= mem_addr + ADDR_WIDTH'(1);
          issue_idx <= issue_idx + LEN_WIDTH'(1);
        end
        lane_cnt <= issue_wend ? '0 : lane_cnt + LW'(1);
      end

      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end

      if (rd_vld) begin
        if (rd_wend) begin
          out_data  <= merged;
          out_valid <= 1'b1;
          out_last  <= rd_final;
          pack      <= '0;
        end else begin
          pack <= merged;
        end
      end

      if (accept) pack <= '0;
    end
  end

endmodule

// File: tb/tb_dram_burst_loader.sv
// Directed bench for dram_burst_loader with a registered-read byte memory model.
module tb_dram_burst_loader;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic [23:0] base_addr;
  logic [19:0] length;
  logic        busy;
  logic        done;
  logic [23:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_dout;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  int checks;
  int failures;

  logic [31:0] words[$];
  logic        lasts[$];
  logic [23:0] addrs[$];
  int          first_vld;
  int          done_cyc;
  int          hold_bad;
  logic        held;
  logic [31:0] held_dat;

  dram_burst_loader #(.ADDR_WIDTH(24), .WORD_BYTES(4), .LEN_WIDTH(20)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .mem_addr(mem_addr), .mem_we(mem_we), .mem_dout(mem_dout),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] byte_at(input logic [23:0] a);
    if (a >= 24'h000100 && a <= 24'h00010F) return 8'(a - 24'h0000FF);
    return a[7:0] ^ 8'h5A;
  endfunction

  always @(posedge clk) mem_dout <= byte_at(mem_addr);

  // Expected words are written little-endian; the big-endian build swaps every lane.
  function automatic logic [31:0] ew(input logic [31:0] le);
`ifdef DRAM_LOADER_BIG_ENDIAN_EN
    return {le[7:0], le[15:8], le[23:16], le[31:24]};
`else
    return le;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered just after a rising edge; that cycle is cycle 0 of the request.
  task automatic run_req(input logic [23:0] b, input logic [19:0] l,
                         input int rlo, input int rhi, input int extra_start);
    words.delete(); lasts.delete(); addrs.delete();
    first_vld = -1; done_cyc = -1; hold_bad = 0; held = 1'b0; held_dat = '0;
    for (int n = 0; n < 200; n++) begin
      start     = (n == 0) || (n == extra_start);
      base_addr = (n == 0) ? b : 24'h000200;
      length    = (n == 0) ? l : 20'd3;
      out_ready = !(n >= rlo && n <= rhi);
      @(negedge clk);
      addrs.push_back(mem_addr);
      if (held && (!out_valid || out_data !== held_dat)) hold_bad++;
      held     = out_valid && !out_ready;
      held_dat = out_data;
      if (out_valid && first_vld < 0) first_vld = n;
      if (out_valid && out_ready) begin
        words.push_back(out_data);
        lasts.push_back(out_last);
      end
      if (done) begin
        done_cyc = n;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    start     = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_data", out_data, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_we", mem_we, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic load of 8 bytes
    run_req(24'h000100, 20'd8, -1, -1, -1);
    chk("basic_first_vld", first_vld, 6);
    chk("basic_done", done_cyc, 11);
    chk("basic_nwords", words.size(), 2);
    chk("basic_w0", words[0], ew(32'h04030201));
    chk("basic_w1", words[1], ew(32'h08070605));
    chk("basic_l0", lasts[0], 0);
    chk("basic_l1", lasts[1], 1);
    chk("basic_a1", addrs[1], 24'h000100);
    chk("basic_a8", addrs[8], 24'h000107);
    chk("basic_we", mem_we, 0);

    // Short tail: 6 bytes
    run_req(24'h000100, 20'd6, -1, -1, -1);
    chk("tail_nwords", words.size(), 2);
    chk("tail_w0", words[0], ew(32'h04030201));
    chk("tail_w1", words[1], ew(32'h00000605));
    chk("tail_l1", lasts[1], 1);
    chk("tail_done", done_cyc, 9);

    // Backpressure: ready low in cycles 6..15
    run_req(24'h000100, 20'd12, 6, 15, -1);
    chk("bp_first_vld", first_vld, 6);
    chk("bp_hold", hold_bad, 0);
    chk("bp_a7", addrs[7], 24'h000106);
    chk("bp_a8", addrs[8], 24'h000107);
    chk("bp_a15", addrs[15], 24'h000107);
    chk("bp_a17", addrs[17], 24'h000108);
    chk("bp_a20", addrs[20], 24'h00010B);
    chk("bp_nwords", words.size(), 3);
    chk("bp_w0", words[0], ew(32'h04030201));
    chk("bp_w1", words[1], ew(32'h08070605));
    chk("bp_w2", words[2], ew(32'h0C0B0A09));
    chk("bp_l2", lasts[2], 1);
    chk("bp_done", done_cyc, 23);

    // Zero-length request
    run_req(24'h000100, 20'd0, -1, -1, -1);
    chk("zero_done", done_cyc, 1);
    chk("zero_first_vld", first_vld, -1);
    chk("zero_nwords", words.size(), 0);

    // Start pulsed while busy is ignored
    run_req(24'h000100, 20'd8, -1, -1, 3);
    chk("busy_start_nwords", words.size(), 2);
    chk("busy_start_w0", words[0], ew(32'h04030201));
    chk("busy_start_w1", words[1], ew(32'h08070605));
    chk("busy_start_done", done_cyc, 11);

    // Address wrap at the top of the space
    run_req(24'hFFFFFE, 20'd4, -1, -1, -1);
    chk("wrap_a1", addrs[1], 24'hFFFFFE);
    chk("wrap_a2", addrs[2], 24'hFFFFFF);
    chk("wrap_a3", addrs[3], 24'h000000);
    chk("wrap_a4", addrs[4], 24'h000001);
    chk("wrap_w0", words[0], ew(32'h5B5AA5A4));
    chk("wrap_l0", lasts[0], 1);
    chk("wrap_done", done_cyc, 7);

    // Reset asserted mid-burst with a word pending
    start = 1'b1; base_addr = 24'h000100; length = 20'd8; out_ready = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    @(negedge clk);
    chk("mid_valid", out_valid, 1);
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_last", out_last, 0);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_done", done, 0);
    @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    run_req(24'h000100, 20'd8, -1, -1, -1);
    chk("post_rst_nwords", words.size(), 2);
    chk("post_rst_w0", words[0], ew(32'h04030201));
    chk("post_rst_w1", words[1], ew(32'h08070605));
    chk("post_rst_done", done_cyc, 11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
